// File: rtl/timer_bank_pkg.sv
// Register offsets and TCON bit positions shared by the timer bank and its channels.
package timer_bank_pkg;
  localparam int TH_OFS    = 0;
  localparam int TL_OFS    = 4;
  localparam int TCON_OFS  = 8;
  localparam int PSC_OFS   = 12;
  localparam int CH_STRIDE = 16;

  localparam int TCON_EN      = 0;
  localparam int TCON_IE      = 1;
  localparam int TCON_PEND    = 2;
  localparam int TCON_ONESHOT = 3;
  localparam int TCON_CASC    = 4;
endpackage

// File: rtl/timer_channel.sv
// One reload timer: TH/TL/TCON/PSC registers, prescaler and wrap logic.
// Bus writes win over counting; a wrap that sets PEND beats a same-cycle clear.
module timer_channel
  import timer_bank_pkg::*;
#(
  parameter int CNT_W    = 32,
  parameter int PSC_W    = 16,
  parameter bit HAS_CASC = 1'b0
) (
  input  logic        sysclk,
  input  logic        reset,
  input  logic        wr_th,
  input  logic        wr_tl,
  input  logic        wr_tcon,
  input  logic        wr_psc,
  input  logic [31:0] wdata,
  input  logic        casc_in,
  output logic        tick,
  output logic        pend,
  output logic [31:0] th_rd,
  output logic [31:0] tl_rd,
  output logic [31:0] tcon_rd,
  output logic [31:0] psc_rd
);
  logic [CNT_W-1:0] th, tl;
  logic [PSC_W-1:0] psc, pc;
  logic en, ie, oneshot, casc, ce;

  // A cascaded channel counts on its neighbour's wrap instead of its prescaler.
  assign ce   = en & (casc ? casc_in : (pc == psc));
  assign tick = ce & (&tl);

  always_ff @(posedge sysclk or negedge reset) begin
    if (!reset) begin
      th      <= '0;
      tl      <= '0;
      psc     <= '0;
      pc      <= '0;
      en      <= 1'b0;
      ie      <= 1'b0;
      oneshot <= 1'b0;
      casc    <= 1'b0;
      pend    <= 1'b0;
    end else begin
      if (wr_psc || !en || casc || pc == psc) pc <= '0;
      else                                    pc <= pc + 1'b1;

      if (wr_th)  th  <= wdata[CNT_W-1:0];
      if (wr_psc) psc <= wdata[PSC_W-1:0];

      if (wr_tl)     tl <= wdata[CNT_W-1:0];
      else if (tick) tl <= th;
      else if (ce)   tl <= tl + 1'b1;

      if (wr_tcon) begin
        en      <= wdata[TCON_EN];
        ie      <= wdata[TCON_IE];
        oneshot <= wdata[TCON_ONESHOT];
        if (HAS_CASC) casc <= wdata[TCON_CASC];
      end else if (tick && oneshot) begin
        en <= 1'b0;
      end

      if (tick && ie)                           pend <= 1'b1;
      else if (wr_tcon && !wdata[TCON_PEND])    pend <= 1'b0;
    end
  end

  always_comb begin
    th_rd   = '0;
    tl_rd   = '0;
    psc_rd  = '0;
    tcon_rd = '0;
    th_rd[CNT_W-1:0]  = th;
    tl_rd[CNT_W-1:0]  = tl;
    psc_rd[PSC_W-1:0] = psc;
    tcon_rd[TCON_EN]      = en;
    tcon_rd[TCON_IE]      = ie;
    tcon_rd[TCON_PEND]    = pend;
    tcon_rd[TCON_ONESHOT] = oneshot;
    tcon_rd[TCON_CASC]    = casc;
  end
endmodule

// File: rtl/timer_bank.sv
// Memory-mapped bank of NUM_CH reload timers with a kernel-mode-masked interrupt.
// TIMER_CASCADE_EN adds TCON.CASC on channels 1..NUM_CH-1 (count on previous channel's wrap).
module timer_bank
  import timer_bank_pkg::*;
#(
  parameter int          NUM_CH    = 4,
  parameter int          CNT_W     = 32,
  parameter int          PSC_W     = 16,
  parameter logic [31:0] BASE_ADDR = 32'h4000_0100
) (
  input  logic              sysclk,
  input  logic              reset,
  input  logic              rd,
  input  logic              wr,
  input  logic [31:0]       addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  input  logic              PC_31,
  output logic              irqout,
  output logic [NUM_CH-1:0] tick
);
  localparam logic [31:0] STAT_OFS = 32'(CH_STRIDE * NUM_CH);

  logic [31:0]       off;
  logic [NUM_CH-1:0] pend;
  logic [31:0]       th_rd   [NUM_CH];
  logic [31:0]       tl_rd   [NUM_CH];
  logic [31:0]       tcon_rd [NUM_CH];
  logic [31:0]       psc_rd  [NUM_CH];

  // Addresses below the base wrap to huge offsets and so decode as unmapped.
  assign off = addr - BASE_ADDR;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic sel, tk, casc_in;
`ifdef TIMER_CASCADE_EN
    localparam bit CASC_OK = (i > 0);
`else
    localparam bit CASC_OK = 1'b0;
`endif
    assign sel = wr && (off[31:4] == 28'(i));

    if (i == 0) begin : g_first
      assign casc_in = 1'b0;
    end else begin : g_next
      assign casc_in = g_ch[i-1].tk;
    end

    timer_channel #(
      .CNT_W    (CNT_W),
      .PSC_W    (PSC_W),
      .HAS_CASC (CASC_OK)
    ) u_ch (
      .sysclk  (sysclk),
      .reset   (reset),
      .wr_th   (sel && off[3:0] == 4'(TH_OFS)),
      .wr_tl   (sel && off[3:0] == 4'(TL_OFS)),
      .wr_tcon (sel && off[3:0] == 4'(TCON_OFS)),
      .wr_psc  (sel && off[3:0] == 4'(PSC_OFS)),
      .wdata   (wdata),
      .casc_in (casc_in),
      .tick    (tk),
      .pend    (pend[i]),
      .th_rd   (th_rd[i]),
      .tl_rd   (tl_rd[i]),
      .tcon_rd (tcon_rd[i]),
      .psc_rd  (psc_rd[i])
    );

    assign tick[i] = tk;
  end

  always_comb begin
    rdata = '0;
    if (rd) begin
      if (off == STAT_OFS) rdata[NUM_CH-1:0] = pend;
      for (int i = 0; i < NUM_CH; i++) begin
        if (off[31:4] == 28'(i)) begin
          case (off[3:0])
            4'(TH_OFS):   rdata = th_rd[i];
            4'(TL_OFS):   rdata = tl_rd[i];
            4'(TCON_OFS): rdata = tcon_rd[i];
            4'(PSC_OFS):  rdata = psc_rd[i];
            default:      ;
          endcase
        end
      end
    end
  end

  assign irqout = !PC_31 && (|pend);
endmodule

// File: tb/tb_timer_bank.sv
// Randomised and directed bus traffic checked cycle by cycle against a behavioural model of the timer bank.
`timescale 1ns/1ps
module tb_timer_bank;
  localparam int          NUM_CH = 4;
  localparam logic [31:0] BASE   = 32'h4000_0100;
  localparam logic [31:0] ONES   = 32'hFFFF_FFFF;

  logic              sysclk = 1'b0;
  logic              reset  = 1'b0;
  logic              rd = 1'b0, wr = 1'b0, PC_31 = 1'b0;
  logic [31:0]       addr = '0, wdata = '0;
  logic [31:0]       rdata;
  logic              irqout;
  logic [NUM_CH-1:0] tick;

  int n_vec = 0;
  int n_err = 0;

  timer_bank dut (
    .sysclk (sysclk),
    .reset  (reset),
    .rd     (rd),
    .wr     (wr),
    .addr   (addr),
    .wdata  (wdata),
    .rdata  (rdata),
    .PC_31  (PC_31),
    .irqout (irqout),
    .tick   (tick)
  );

  always #5 sysclk = ~sysclk;

  // Reference model state, one entry per channel.
  logic [31:0] m_th [NUM_CH], m_tl [NUM_CH], m_pc [NUM_CH], m_psc [NUM_CH];
  bit m_en [NUM_CH], m_ie [NUM_CH], m_pend [NUM_CH], m_os [NUM_CH], m_casc [NUM_CH];
  bit m_ce [NUM_CH], m_tk [NUM_CH];

  logic [31:0]       obs_rd;
  logic [NUM_CH-1:0] obs_tick;
  logic              obs_irq;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void m_eval();
    for (int i = 0; i < NUM_CH; i++) begin
      if (!m_en[i])       m_ce[i] = 1'b0;
      else if (m_casc[i]) m_ce[i] = (i > 0) && m_tk[i-1];
      else                m_ce[i] = (m_pc[i] == m_psc[i]);
      m_tk[i] = m_ce[i] && (m_tl[i] == ONES);
    end
  endfunction

  function automatic logic [31:0] m_read(input logic r, input logic [31:0] a);
    logic [31:0] off, v;
    int ch;
    off = a - BASE;
    v   = '0;
    if (!r || off[1:0] != 2'b00) return '0;
    if (off == 32'(16 * NUM_CH)) begin
      for (int i = 0; i < NUM_CH; i++) v[i] = m_pend[i];
      return v;
    end
    if (off > 32'(16 * NUM_CH)) return '0;
    ch = int'(off >> 4);
    case (off[3:2])
      2'd0: v = m_th[ch];
      2'd1: v = m_tl[ch];
      2'd2: v = {27'd0, m_casc[ch], m_os[ch], m_pend[ch], m_ie[ch], m_en[ch]};
      default: v = m_psc[ch];
    endcase
    return v;
  endfunction

  function automatic void m_step(input logic w, input logic [31:0] a, input logic [31:0] d);
    logic [31:0] off;
    bit hit;
    int ch;
    off = a - BASE;
    hit = w && off[1:0] == 2'b00 && off < 32'(16 * NUM_CH);
    ch  = int'(off >> 4);
    m_eval();
    for (int i = 0; i < NUM_CH; i++) begin
      bit old_ie;
      old_ie = m_ie[i];
      if (!m_en[i] || m_casc[i] || m_pc[i] == m_psc[i]) m_pc[i] = 0;
      else m_pc[i] = m_pc[i] + 1;
      if (m_tk[i])      m_tl[i] = m_th[i];
      else if (m_ce[i]) m_tl[i] = m_tl[i] + 1;
      if (m_tk[i] && m_os[i]) m_en[i] = 1'b0;
      if (hit && ch == i) begin
        case (off[3:2])
          2'd0: m_th[i] = d;
          2'd1: m_tl[i] = d;
          2'd2: begin
            m_en[i] = d[0];
            m_ie[i] = d[1];
            m_os[i] = d[3];
            if (!d[2]) m_pend[i] = 1'b0;
`ifdef TIMER_CASCADE_EN
            if (i > 0) m_casc[i] = d[4];
`endif
          end
          default: begin
            m_psc[i] = {16'd0, d[15:0]};
            m_pc[i]  = 0;
          end
        endcase
      end
      if (m_tk[i] && old_ie) m_pend[i] = 1'b1;
    end
  endfunction

  // Drive one bus cycle, check the combinational outputs mid-cycle, then advance the model.
  task automatic do_cycle(input logic r, input logic w, input logic [31:0] a,
                          input logic [31:0] d, input logic p);
    logic [NUM_CH-1:0] et;
    logic              ei;
    logic [31:0]       er;
    rd = r; wr = w; addr = a; wdata = d; PC_31 = p;
    m_eval();
    ei = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      et[i] = m_tk[i];
      if (m_pend[i]) ei = !p;
    end
    er = m_read(r, a);
    #4;
    obs_tick = tick; obs_irq = irqout; obs_rd = rdata;
    check_val("tick", 32'(tick), 32'(et));
    check_val("irqout", 32'(irqout), 32'(ei));
    check_val($sformatf("rdata@%h", a), rdata, er);
    @(posedge sysclk);
    m_step(w, a, d);
    #1;
  endtask

  task automatic wr_reg(input int ch, input int ofs, input logic [31:0] d);
    do_cycle(1'b0, 1'b1, BASE + 32'(16 * ch + ofs), d, 1'b0);
  endtask

  task automatic rd_reg(input int ch, input int ofs);
    do_cycle(1'b1, 1'b0, BASE + 32'(16 * ch + ofs), 32'd0, 1'b0);
  endtask

  task automatic idle();
    do_cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b0);
  endtask

  initial begin
    int cnt, first;
    for (int i = 0; i < NUM_CH; i++) begin
      m_th[i] = 0; m_tl[i] = 0; m_pc[i] = 0; m_psc[i] = 0;
      m_en[i] = 0; m_ie[i] = 0; m_pend[i] = 0; m_os[i] = 0; m_casc[i] = 0;
    end
    #22 reset = 1'b1;
    @(posedge sysclk);
    #1;

    // Reset state: every register and IRQ_STAT read 0.
    for (int c = 0; c < NUM_CH; c++)
      for (int o = 0; o < 16; o += 4) rd_reg(c, o);
    rd_reg(NUM_CH, 0);
    check_val("rst_irq", 32'(obs_irq), 32'd0);
    check_val("rst_tick", 32'(obs_tick), 32'd0);

    // Channel 0 periodic, period 4.
    wr_reg(0, 0, 32'hFFFF_FFFC);
    wr_reg(0, 4, 32'hFFFF_FFFC);
    wr_reg(0, 12, 32'd0);
    wr_reg(0, 8, 32'd3);
    cnt = 0;
    for (int n = 0; n < 12; n++) begin
      idle();
      cnt += int'(obs_tick[0]);
    end
    check_val("ch0_ticks_in_12", 32'(cnt), 32'd3);
    do_cycle(1'b0, 1'b0, 32'd0, 32'd0, 1'b1);
    check_val("irq_masked", 32'(obs_irq), 32'd0);
    idle();
    check_val("irq_unmasked", 32'(obs_irq), 32'd1);
    wr_reg(0, 8, 32'd3);
    rd_reg(NUM_CH, 0);
    check_val("ch0_pend_cleared", obs_rd, 32'd0);
    wr_reg(0, 8, 32'd0);
    wr_reg(0, 8, 32'd0);

    // Channel 1 one-shot with PSC=2.
    wr_reg(1, 12, 32'd2);
    wr_reg(1, 0, 32'hFFFF_FFFE);
    wr_reg(1, 4, 32'hFFFF_FFFE);
    wr_reg(1, 8, 32'd9);
    cnt = 0; first = 0;
    for (int n = 1; n <= 20; n++) begin
      idle();
      if (obs_tick[1]) begin
        cnt++;
        if (first == 0) first = n;
      end
    end
    check_val("ch1_oneshot_ticks", 32'(cnt), 32'd1);
    check_val("ch1_oneshot_delay", 32'(first), 32'd6);
    rd_reg(1, 8);
    check_val("ch1_tcon_after", obs_rd, 32'd8);
    rd_reg(1, 4);
    check_val("ch1_tl_after", obs_rd, 32'hFFFF_FFFE);

    // Channel 2: PEND set beats same-cycle clear; TL write beats wrap reload.
    wr_reg(2, 12, 32'd0);
    wr_reg(2, 0, 32'hFFFF_FFFE);
    wr_reg(2, 4, 32'hFFFF_FFFE);
    wr_reg(2, 8, 32'd3);
    idle();
    wr_reg(2, 8, 32'd3);
    check_val("ch2_wrap_on_clear", 32'(obs_tick[2]), 32'd1);
    rd_reg(2, 8);
    check_val("ch2_pend_kept", obs_rd, 32'd7);
    wr_reg(2, 4, 32'd5);
    check_val("ch2_wrap_on_tlwr", 32'(obs_tick[2]), 32'd1);
    rd_reg(2, 4);
    check_val("ch2_tl_written", obs_rd, 32'd5);
    wr_reg(2, 8, 32'd0);

    // Unmapped and read-only addresses; rd=0 returns 0.
    do_cycle(1'b1, 1'b0, BASE + 32'h7C, 32'd0, 1'b0);
    check_val("unmapped_read", obs_rd, 32'd0);
    do_cycle(1'b0, 1'b1, BASE + 32'h7C, ONES, 1'b0);
    do_cycle(1'b0, 1'b1, BASE + 32'(16 * NUM_CH), ONES, 1'b0);
    do_cycle(1'b0, 1'b1, BASE - 32'd4, ONES, 1'b0);
    for (int o = 0; o < 16 * NUM_CH + 8; o += 4)
      do_cycle(1'b0, 1'b0, BASE + 32'(o), 32'd0, 1'b0);

    // Cascade: ch0 wraps every cycle, ch1 counts those wraps.
    wr_reg(0, 0, ONES);
    wr_reg(0, 4, ONES);
    wr_reg(1, 4, 32'd0);
    wr_reg(1, 8, 32'h11);
    wr_reg(0, 8, 32'd1);
    for (int n = 0; n < 5; n++) idle();
    rd_reg(1, 4);
`ifdef TIMER_CASCADE_EN
    check_val("casc_ch1_tl", obs_rd, 32'd5);
    rd_reg(1, 8);
    check_val("casc_tcon", obs_rd, 32'h11);
`else
    rd_reg(1, 8);
    check_val("casc_tcon_absent", obs_rd, 32'h1);
`endif
    for (int c = 0; c < NUM_CH; c++) wr_reg(c, 8, 32'd0);

    // Random traffic biased toward near-wrap counts and small prescalers.
    for (int n = 0; n < 2500; n++) begin
      int ch, k;
      logic [31:0] a, d;
      ch = int'($urandom_range(0, NUM_CH - 1));
      k  = int'($urandom_range(0, 9));
      if (k < 8)       a = BASE + 32'(16 * ch + 4 * (k % 4));
      else if (k == 8) a = BASE + 32'(16 * NUM_CH);
      else begin
        case ($urandom_range(0, 2))
          0:       a = BASE + 32'h7C;
          1:       a = BASE - 32'd4;
          default: a = BASE + 32'(16 * ch + 1);
        endcase
      end
      case (a[3:2])
        2'd0, 2'd1: d = ($urandom_range(0, 3) == 0) ? $urandom : ONES - $urandom_range(0, 5);
        2'd2:       d = $urandom_range(0, 31);
        default:    d = ($urandom_range(0, 7) == 0) ? $urandom : $urandom_range(0, 3);
      endcase
      do_cycle(1'($urandom_range(0, 1)), $urandom_range(0, 2) == 0, a, d,
               $urandom_range(0, 3) == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
